rf_scoreboard: RTL
==================

Name: rf_scoreboard

Overview:
- Per-register in-flight writer tracker between decode and writeback.
- Counts outstanding GPR writers issued from ID and not yet retired by WB.
- Tracks which of those writers are loads whose data cannot be forwarded yet.
- Generates the decode RAW stall and forward-needed hints, replacing per-stage compare chains.

Parameters:
NREG, 32, number of architectural GPRs; r0 is never tracked.
CNT_W, 2, width of each pending-writer counter; the maximum count is 2**CNT_W-1.

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
flush  in  1  synchronous clear of all tracking state (pipeline flush/exception)
ds_valid  in  1  decode holds a valid instruction
ds_need_rj  in  1  instruction reads rj
ds_need_rkd  in  1  instruction reads rk/rd
ds_raddr1  in  5  rj index
ds_raddr2  in  5  rk/rd index
ds_gr_we  in  1  instruction writes a GPR
ds_dest  in  5  destination GPR
ds_is_load  in  1  result is produced in MEM (load)
ds_fire  in  1  decode-to-execute handshake completed this cycle
ms_ld_done  in  1  a load's data became forwardable (leaving MEM)
ms_ld_dest  in  5  destination of that load
ws_retire  in  1  writeback committed a GPR write
ws_dest  in  5  retired destination
ds_stall  out  1  decode must not issue
rj_fwd  out  1  rj has an in-flight writer (take the forward path)
rkd_fwd  out  1  rk/rd has an in-flight writer
pend_vec  out  32  bit i = register i has a non-zero pending count
err  out  1  sticky protocol-violation flag

Behaviour:
- State:
  - cnt[i] and ldcnt[i] are CNT_W-bit registers for i = 1..NREG-1.
  - Index 0 reads as 0 and ignores all updates.
- Reset (resetn=0, async):
  - All cnt, ldcnt and err clear to 0.
  - Outputs: ds_stall=0, rj_fwd=0, rkd_fwd=0, pend_vec=0, err=0.
- Combinational outputs, zero latency from current state:
  - rj_fwd = ds_valid & ds_need_rj & cnt[raddr1]!=0.
  - rkd_fwd = ds_valid & ds_need_rkd & cnt[raddr2]!=0.
  - ld_hazard = (rj_fwd & ldcnt[raddr1]!=0) | (rkd_fwd & ldcnt[raddr2]!=0).
  - full = ds_valid & ds_gr_we & dest!=0 & cnt[dest]==max.
  - ds_stall = ld_hazard | full.
  - Stall sees state only; same-cycle ms_ld_done/ws_retire do not release it until the next cycle.
- Sequential update on posedge clk, all events in the same cycle summed per register:
  - Issue: ds_fire & ds_gr_we & ds_dest!=0 adds +1 to cnt[ds_dest], and +1 to ldcnt[ds_dest] if ds_is_load.
  - Load done: ms_ld_done & ms_ld_dest!=0 adds -1 to ldcnt[ms_ld_dest].
  - Retire: ws_retire & ws_dest!=0 adds -1 to cnt[ws_dest].
  - Issue and retire on the same register in one cycle leave cnt unchanged; issue-load and ld_done on the same register leave ldcnt unchanged.
  - Counters saturate, never wrap.
- err sets, and stays set until reset, on any of:
  - decrement of a zero counter (the counter stays 0);
  - increment beyond max (the counter stays max);
  - ds_fire while ds_stall=1 (that issue is still counted);
  - ldcnt greater than cnt after an update.
- flush:
  - Next edge clears all cnt and ldcnt, overriding same-cycle events.
  - err is not cleared.
  - ds_fire/ws_retire in the flush cycle are discarded.
- pend_vec is registered state: a bit reflects a counter after its update edge.

Test Plan:
- Reset release, then ds_valid=1, need_rj=1, raddr1=5 with no issues → ds_stall=0, rj_fwd=0, pend_vec=0.
- Fire add r3 (non-load); next cycle decode reads r3 → rj_fwd=1, ds_stall=0, pend_vec[3]=1. ws_retire r3 → pend_vec[3]=0 the next cycle.
- Fire ld.w r4, then decode needs r4 → ds_stall=1. Pulse ms_ld_done r4 → ds_stall=0 the following cycle, with rj_fwd=1 until ws_retire r4.
- Fire three writers to r7 (cnt=3), then a fourth decode writing r7 → ds_stall=1 via full. Same-cycle ws_retire r7 → stall persists that cycle, clears the next, cnt stays 3 after the re-issue.
- Same-cycle ds_fire r9 and ws_retire r9 with cnt[9]=1 → cnt[9]=1, err=0. A ws_retire r10 with cnt[10]=0 → err=1 and sticky, cnt[10]=0.
- Fire to r0 → pend_vec=0, no stall. flush with pending r2/r6 plus a same-cycle ds_fire r8 → all counts 0, pend_vec=0, err unchanged. Assert resetn mid-run → immediate clear.

Source files
------------

// File: rtl/rf_scoreboard.sv
// Per-register in-flight GPR writer tracker between decode and writeback.
// Each tracked register has a writer counter and a load-writer counter. Together they give the decode RAW stall and forward hints.

module rf_sb_entry #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush_i,
  input  logic             inc_i,
  input  logic             dec_i,
  input  logic             ld_inc_i,
  input  logic             ld_dec_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic [CNT_W-1:0] ld_cnt_o,
  output logic             pend_o,
  output logic             err_o
);
  localparam logic [CNT_W-1:0] MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] cnt_q, cnt_d, ld_q, ld_d;
  logic             pend_q;
  logic             cnt_err, ld_err;

  // Same-cycle +1/-1 cancel out. A lone step past either end saturates and flags.
  always_comb begin
    cnt_d   = cnt_q;
    cnt_err = 1'b0;
    case ({inc_i, dec_i})
      2'b10: if (cnt_q == MAX) cnt_err = 1'b1; else cnt_d = cnt_q + CNT_W'(1);
      2'b01: if (cnt_q == '0)  cnt_err = 1'b1; else cnt_d = cnt_q - CNT_W'(1);
      default: ;
    endcase
  end

  always_comb begin
    ld_d   = ld_q;
    ld_err = 1'b0;
    case ({ld_inc_i, ld_dec_i})
      2'b10: if (ld_q == MAX) ld_err = 1'b1; else ld_d = ld_q + CNT_W'(1);
      2'b01: if (ld_q == '0)  ld_err = 1'b1; else ld_d = ld_q - CNT_W'(1);
      default: ;
    endcase
  end

  assign err_o = ~flush_i & (cnt_err | ld_err | (ld_d > cnt_d));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q  <= '0;
      ld_q   <= '0;
      pend_q <= 1'b0;
    end else if (flush_i) begin
      cnt_q  <= '0;
      ld_q   <= '0;
      pend_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      ld_q   <= ld_d;
      pend_q <= (cnt_d != '0);
    end
  end

  assign cnt_o    = cnt_q;
  assign ld_cnt_o = ld_q;
  assign pend_o   = pend_q;
endmodule

module rf_scoreboard #(
  parameter int NREG  = 32,
  parameter int CNT_W = 2
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            flush,
  input  logic            ds_valid,
  input  logic            ds_need_rj,
  input  logic            ds_need_rkd,
  input  logic [4:0]      ds_raddr1,
  input  logic [4:0]      ds_raddr2,
  input  logic            ds_gr_we,
  input  logic [4:0]      ds_dest,
  input  logic            ds_is_load,
  input  logic            ds_fire,
  input  logic            ms_ld_done,
  input  logic [4:0]      ms_ld_dest,
  input  logic            ws_retire,
  input  logic [4:0]      ws_dest,
  output logic            ds_stall,
  output logic            rj_fwd,
  output logic            rkd_fwd,
  output logic [NREG-1:0] pend_vec,
  output logic            err
);
  localparam logic [CNT_W-1:0] MAX = {CNT_W{1'b1}};

  logic [NREG-1:0][CNT_W-1:0] cnt, ldcnt;
  logic [NREG-1:0]            pend, err_evt;
  logic                       issue, ld_done, retire;
  logic                       ld_hazard, full, fire_err;
  logic                       err_q, err_d;

  assign issue   = ds_fire & ds_gr_we & (ds_dest != 5'd0);
  assign ld_done = ms_ld_done & (ms_ld_dest != 5'd0);
  assign retire  = ws_retire & (ws_dest != 5'd0);

  // r0 is hardwired: never pending, never updated.
  assign cnt[0]     = '0;
  assign ldcnt[0]   = '0;
  assign pend[0]    = 1'b0;
  assign err_evt[0] = 1'b0;

  for (genvar i = 1; i < NREG; i++) begin : g_ent
    rf_sb_entry #(.CNT_W(CNT_W)) u_ent (
      .clk      (clk),
      .resetn   (resetn),
      .flush_i  (flush),
      .inc_i    (issue   & (ds_dest    == 5'(i))),
      .dec_i    (retire  & (ws_dest    == 5'(i))),
      .ld_inc_i (issue   & ds_is_load & (ds_dest == 5'(i))),
      .ld_dec_i (ld_done & (ms_ld_dest == 5'(i))),
      .cnt_o    (cnt[i]),
      .ld_cnt_o (ldcnt[i]),
      .pend_o   (pend[i]),
      .err_o    (err_evt[i])
    );
  end

  // Hints look at current state only; same-cycle releases land next cycle.
  assign rj_fwd    = ds_valid & ds_need_rj  & (cnt[ds_raddr1] != '0);
  assign rkd_fwd   = ds_valid & ds_need_rkd & (cnt[ds_raddr2] != '0);
  assign ld_hazard = (rj_fwd  & (ldcnt[ds_raddr1] != '0)) |
                     (rkd_fwd & (ldcnt[ds_raddr2] != '0));
  assign full      = ds_valid & ds_gr_we & (ds_dest != 5'd0) & (cnt[ds_dest] == MAX);
  assign ds_stall  = ld_hazard | full;

  assign fire_err = ds_fire & ds_stall & ~flush;
  assign err_d    = err_q | fire_err | (|err_evt);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) err_q <= 1'b0;
    else         err_q <= err_d;
  end

  assign err      = err_q;
  assign pend_vec = pend;
endmodule
